// File: rtl/mem_io_pkg.sv
// mem_io_pkg: shared constants and types for the memory/I-O responder.
//   IO_SEL            value of the region-select bits that marks the I/O window
//   IO_UART / IO_CLK  decoded I/O register addresses
//   DEC_HI            top bit of the decoded address field
//   SEL_HI / SEL_LO   region-select bit range
//   tx_entry_t        TX FIFO entry: byte plus stop-byte tag
package mem_io_pkg;

    localparam int DEC_HI = 17;
    localparam int SEL_HI = 17;
    localparam int SEL_LO = 16;

    localparam logic [1:0]  IO_SEL  = 2'b11;
    localparam logic [17:0] IO_UART = 18'h30000;
    localparam logic [17:0] IO_CLK  = 18'h30004;

    typedef struct packed {
        logic       stop;
        logic [7:0] data;
    } tx_entry_t;

endpackage

// File: rtl/mem_io_responder_tx_fifo.sv
// tx_fifo: parameterised synchronous FIFO with synchronous active-high reset.
//   i_clk, i_rst      clock, reset (clears pointers and count)
//   i_push, i_entry   push request and data
//   i_pop             pop request (ignored while empty)
//   o_entry           head entry, forced to zero while empty
//   o_count           occupancy, DEPTH_BITS+1 bits
//   o_full, o_empty   status flags
module tx_fifo #(
    parameter int DEPTH_BITS = 4,
    parameter int WIDTH      = 9
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [WIDTH-1:0]      i_entry,
    output logic [WIDTH-1:0]      o_entry,
    output logic [DEPTH_BITS:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_BITS-1:0] r_wr_ptr;
    logic [DEPTH_BITS-1:0] r_rd_ptr;
    logic [DEPTH_BITS:0]   r_count;

    logic w_pop;
    logic w_push;

    assign o_empty = (r_count == '0);
    // count never exceeds DEPTH, so the MSB alone means full
    assign o_full  = r_count[DEPTH_BITS];
    assign o_count = r_count;
    assign o_entry = o_empty ? '0 : r_mem[r_rd_ptr];

    assign w_pop  = i_pop && !o_empty;
    // a pop in the same cycle frees the slot a full FIFO needs
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: byte-wide RAM plus memory-mapped I/O answering one request
// per cycle. Reads return one cycle later, writes commit at the request edge.
//   clk_in, rst_in           clock, synchronous active-high reset
//   mem_a, mem_wr, mem_wdata request (address, direction, write byte)
//   mem_rdata                read byte, registered
//   io_buffer_full           TX FIFO near-full back-pressure
//   tx_data/tx_valid/tx_ready byte stream to the UART transmitter
//   rx_data/rx_valid         byte stream from the UART receiver (MEM_IO_UART_RX_EN)
//   rx_pop                   RX consume strobe (tied 0 without MEM_IO_UART_RX_EN)
//   program_end              pulse after the stop byte is handed to the transmitter
//   tx_overflow              sticky: a TX push was dropped
// Optional feature macro: MEM_IO_UART_RX_EN enables UART receive reads at 0x30000.
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int ADDR_BITS       = 17,
    parameter int FIFO_DEPTH_BITS = 4,
    parameter int FULL_MARGIN     = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_wdata,
    output logic [7:0]  mem_rdata,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
`ifdef MEM_IO_UART_RX_EN
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
`endif
    output logic        rx_pop,
    output logic        program_end,
    output logic        tx_overflow
);

    localparam int unsigned FULL_THR = (1 << FIFO_DEPTH_BITS) - FULL_MARGIN;

    logic [7:0]  r_ram [2**ADDR_BITS];
    logic [7:0]  r_rdata;
    logic [31:0] r_cnt;
    logic [31:0] r_snap;
    logic        r_pend;
    logic        r_ovf;

    logic [DEC_HI:0]          w_addr;
    logic [ADDR_BITS-1:0]     w_ram_idx;
    logic                     w_is_io;
    logic                     w_io_rd;
    logic                     w_push;
    tx_entry_t                w_push_entry;
    tx_entry_t                w_head;
    logic [FIFO_DEPTH_BITS:0] w_count;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_handshake;
    logic [7:0]               w_rd_byte;
    logic                     w_unused;

    assign w_addr    = mem_a[DEC_HI:0];
    assign w_ram_idx = mem_a[ADDR_BITS-1:0];
    assign w_is_io   = (w_addr[SEL_HI:SEL_LO] == IO_SEL);
    assign w_io_rd   = w_is_io && !mem_wr;
    assign w_unused  = &{1'b0, mem_a[31:DEC_HI+1]};

    // 0x00 to the UART register is a no-op; the clock register pushes the stop tag
    assign w_push = w_is_io && mem_wr &&
                    (((w_addr == IO_UART) && (mem_wdata != 8'h00)) || (w_addr == IO_CLK));

    always_comb begin
        w_push_entry      = '0;
        w_push_entry.stop = (w_addr == IO_CLK);
        w_push_entry.data = (w_addr == IO_CLK) ? 8'h00 : mem_wdata;
    end

    tx_fifo #(
        .DEPTH_BITS (FIFO_DEPTH_BITS),
        .WIDTH      ($bits(tx_entry_t))
    ) u_tx_fifo (
        .i_clk   (clk_in),
        .i_rst   (rst_in),
        .i_push  (w_push),
        .i_pop   (tx_ready),
        .i_entry (w_push_entry),
        .o_entry (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_handshake    = !w_empty && tx_ready;
    assign tx_valid       = !w_empty;
    assign tx_data        = w_head.data;
    assign io_buffer_full = (32'(w_count) >= FULL_THR);
    assign mem_rdata      = r_rdata;
    assign program_end    = r_pend;
    assign tx_overflow    = r_ovf;

`ifdef MEM_IO_UART_RX_EN
    assign rx_pop = w_io_rd && (w_addr == IO_UART) && rx_valid;
`else
    assign rx_pop = 1'b0;
`endif

    always_comb begin
        w_rd_byte = 8'h00;
        if (w_is_io) begin
            case (w_addr)
                IO_UART: begin
`ifdef MEM_IO_UART_RX_EN
                    if (rx_valid) w_rd_byte = rx_data;
`endif
                end
                IO_CLK:           w_rd_byte = r_cnt[7:0];
                IO_CLK + 18'd1:   w_rd_byte = r_snap[15:8];
                IO_CLK + 18'd2:   w_rd_byte = r_snap[23:16];
                IO_CLK + 18'd3:   w_rd_byte = r_snap[31:24];
                default:          w_rd_byte = 8'h00;
            endcase
        end else begin
            w_rd_byte = r_ram[w_ram_idx];
        end
    end

    // RAM contents survive reset so a preloaded image stays intact
    always_ff @(posedge clk_in) begin
        if (mem_wr && !w_is_io) begin
            r_ram[w_ram_idx] <= mem_wdata;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_rdata <= 8'h00;
            r_cnt   <= 32'd0;
            r_snap  <= 32'd0;
            r_pend  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
            if (!mem_wr) r_rdata <= w_rd_byte;
            // low byte is returned live; upper bytes come from this snapshot
            if (w_io_rd && (w_addr == IO_CLK)) r_snap <= r_cnt;
            r_pend <= w_handshake && w_head.stop;
            if (w_push && w_full && !w_handshake) r_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
`ifdef MEM_IO_UART_RX_EN
    logic [7:0]  rx_data;
    logic        rx_valid;
`endif
    logic        rx_pop;
    logic        program_end;
    logic        tx_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q [16];
    logic       pe_seen;

    always #5 clk_in = ~clk_in;

    mem_io_responder dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
`ifdef MEM_IO_UART_RX_EN
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
`endif
        .rx_pop         (rx_pop),
        .program_end    (program_end),
        .tx_overflow    (tx_overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        mem_wr    = 1'b1;
        mem_a     = a;
        mem_wdata = d;
        step();
        mem_wr    = 1'b0;
        mem_a     = 32'h0;
    endtask

    task automatic rd(input logic [31:0] a);
        mem_wr = 1'b0;
        mem_a  = a;
        step();
    endtask

    initial begin
        rst_in    = 1'b1;
        mem_a     = 32'h0;
        mem_wr    = 1'b0;
        mem_wdata = 8'h00;
        tx_ready  = 1'b0;
`ifdef MEM_IO_UART_RX_EN
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
`endif
        step();
        check("rst_rdata", 32'(mem_rdata), 32'h0);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_buf_full", 32'(io_buffer_full), 32'h0);
        check("rst_prog_end", 32'(program_end), 32'h0);
        check("rst_overflow", 32'(tx_overflow), 32'h0);
        check("rst_rx_pop", 32'(rx_pop), 32'h0);
        rst_in = 1'b0;

        // counter word sampled when the counter reads 100, then 300 (0x12C)
        repeat (100) step();
        rd(32'h30004); check("cnt100_b0", 32'(mem_rdata), 32'd100);
        rd(32'h30005); check("cnt100_b1", 32'(mem_rdata), 32'h00);
        rd(32'h30006); check("cnt100_b2", 32'(mem_rdata), 32'h00);
        rd(32'h30007); check("cnt100_b3", 32'(mem_rdata), 32'h00);
        mem_a = 32'h0;
        repeat (196) step();
        rd(32'h30004); check("cnt300_b0", 32'(mem_rdata), 32'h2C);
        rd(32'h30005); check("cnt300_b1", 32'(mem_rdata), 32'h01);
        rd(32'h30006); check("cnt300_b2", 32'(mem_rdata), 32'h00);
        rd(32'h30007); check("cnt300_b3", 32'(mem_rdata), 32'h00);

        // RAM
        wr(32'h00010, 8'hA5);
        rd(32'h00010); check("ram_rt_10", 32'(mem_rdata), 32'hA5);
        wr(32'h00011, 8'h5A);
        check("ram_hold_on_wr", 32'(mem_rdata), 32'hA5);
        rd(32'h00011); check("ram_rt_11", 32'(mem_rdata), 32'h5A);
        rd(32'h00010); check("ram_b2b_10", 32'(mem_rdata), 32'hA5);
        wr(32'h1FFFF, 8'h3C);
        rd(32'h1FFFF); check("ram_top", 32'(mem_rdata), 32'h3C);
        rd(32'h30008); check("io_other_rd", 32'(mem_rdata), 32'h00);

        // TX back-pressure
        tx_ready = 1'b0;
        wr(32'h30000, 8'h48);
        check("tx_first_valid", 32'(tx_valid), 32'h1);
        check("tx_first_data", 32'(tx_data), 32'h48);
        wr(32'h30000, 8'h69);
        wr(32'h30000, 8'h00);
        wr(32'h30000, 8'h21);
        check("tx_head_kept", 32'(tx_data), 32'h48);
        for (int i = 1; i <= 13; i++) begin
            wr(32'h30000, 8'(i));
            if (i == 10) check("buf_full_13", 32'(io_buffer_full), 32'h0);
            if (i == 11) check("buf_full_14", 32'(io_buffer_full), 32'h1);
        end
        check("ovf_at_16", 32'(tx_overflow), 32'h0);
        wr(32'h30000, 8'h99);
        check("ovf_set", 32'(tx_overflow), 32'h1);

        // push and pop together at full: 0x48 leaves, 0x77 enters
        tx_ready  = 1'b1;
        check("full_pp_head", 32'(tx_data), 32'h48);
        wr(32'h30000, 8'h77);
        exp_q[0] = 8'h69;
        exp_q[1] = 8'h21;
        for (int i = 2; i < 15; i++) exp_q[i] = 8'(i - 1);
        exp_q[15] = 8'h77;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain_valid_%0d", i), 32'(tx_valid), 32'h1);
            check($sformatf("drain_data_%0d", i), 32'(tx_data), 32'(exp_q[i]));
            step();
        end
        check("drain_empty", 32'(tx_valid), 32'h0);
        check("drain_buf_full", 32'(io_buffer_full), 32'h0);
        check("ovf_sticky", 32'(tx_overflow), 32'h1);

        // push and pop together at empty
        wr(32'h30000, 8'h55);
        check("empty_pp_valid", 32'(tx_valid), 32'h1);
        check("empty_pp_data", 32'(tx_data), 32'h55);
        step();
        check("empty_pp_drain", 32'(tx_valid), 32'h0);

        // stop sequence
        wr(32'h30000, 8'h41);
        check("stop_a_data", 32'(tx_data), 32'h41);
        check("stop_a_pe", 32'(program_end), 32'h0);
        wr(32'h30004, 8'hEE);
        check("stop_b_data", 32'(tx_data), 32'h00);
        check("stop_b_valid", 32'(tx_valid), 32'h1);
        check("stop_b_pe", 32'(program_end), 32'h0);
        step();
        check("stop_c_pe", 32'(program_end), 32'h1);
        check("stop_c_valid", 32'(tx_valid), 32'h0);
        step();
        check("stop_d_pe", 32'(program_end), 32'h0);

        // reset mid-stream with a stop byte queued
        tx_ready = 1'b0;
        wr(32'h30000, 8'h01);
        wr(32'h30000, 8'h02);
        wr(32'h30000, 8'h03);
        wr(32'h30000, 8'h04);
        wr(32'h30004, 8'h00);
        check("mid_queued", 32'(tx_valid), 32'h1);
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        check("mid_tx_valid", 32'(tx_valid), 32'h0);
        check("mid_tx_data", 32'(tx_data), 32'h0);
        check("mid_buf_full", 32'(io_buffer_full), 32'h0);
        check("mid_overflow", 32'(tx_overflow), 32'h0);
        check("mid_rdata", 32'(mem_rdata), 32'h0);
        tx_ready = 1'b1;
        pe_seen  = 1'b0;
        repeat (5) begin
            step();
            pe_seen = pe_seen | program_end;
        end
        check("mid_no_pe", 32'(pe_seen), 32'h0);
        check("mid_still_empty", 32'(tx_valid), 32'h0);

        // RAM survives reset; UART register reads
        rd(32'h00010); check("ram_after_rst", 32'(mem_rdata), 32'hA5);
`ifdef MEM_IO_UART_RX_EN
        rx_valid = 1'b1;
        rx_data  = 8'h37;
        mem_a    = 32'h30000;
        #1;
        check("rx_pop_high", 32'(rx_pop), 32'h1);
        step();
        check("rx_rdata", 32'(mem_rdata), 32'h37);
        rx_valid = 1'b0;
        #1;
        check("rx_pop_low", 32'(rx_pop), 32'h0);
        step();
        check("rx_empty_rdata", 32'(mem_rdata), 32'h00);
`else
        mem_a = 32'h30000;
        #1;
        check("rx_pop_tied", 32'(rx_pop), 32'h0);
        step();
        check("uart_rd_zero", 32'(mem_rdata), 32'h00);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Bus responder for the CPU core's byte-wide memory port: single-port RAM plus memory-mapped I/O (UART transmit, optional UART receive, cycle counter, program stop). Sits opposite the memory controller and answers its byte requests. Returns a read byte one cycle after the request, commits writes at the request edge, and drives the `io_buffer_full` back-pressure signal. Serves as the simulation memory system and as the FPGA-side RAM/UART glue.

## Interface
- `ADDR_BITS`, 17: RAM holds 2^ADDR_BITS bytes, indexed by `mem_a[ADDR_BITS-1:0]`.
- `FIFO_DEPTH_BITS`, 4: TX FIFO depth is 2^FIFO_DEPTH_BITS.
- `FULL_MARGIN`, 2: `io_buffer_full` asserts this many entries before the FIFO is truly full.

- `clk_in` in 1: the single clock.
- `rst_in` in 1: reset, synchronous, active-high.
- `mem_a` in 32: byte address; only [17:0] is decoded.
- `mem_wr` in 1: 1 = write, 0 = read.
- `mem_wdata` in 8: write byte.
- `mem_rdata` out 8: read byte, valid the cycle after the read request.
- `io_buffer_full` out 1: TX FIFO near-full.
- `tx_data` out 8, `tx_valid` out 1, `tx_ready` in 1: byte stream to the UART transmitter.
- `rx_data` in 8, `rx_valid` in 1, `rx_pop` out 1: byte stream from the UART receiver (`MEM_IO_UART_RX_EN` only).
- `program_end` out 1: one-cycle pulse when the stop byte leaves the TX interface.
- `tx_overflow` out 1: sticky flag, set when a TX push is dropped.

## Operation
- **Address decode.** I/O when `mem_a[17:16]==2'b11`; otherwise RAM.
- **Request rate.** Every cycle is a request, with no idle qualifier. A read to the RAM region with no side effects is harmless.
- **RAM write.** The byte is written at the request edge.
- **RAM read.** `mem_rdata` takes `ram[addr]` at the edge. The value is held until the next read.
- **Read-after-write to the same address on consecutive cycles** returns the new byte.
- **Cycle counter.** 32-bit, reset 0, increments every cycle, wraps from 0xFFFFFFFF to 0.
- **Read 0x30004.** Returns counter[7:0] and snapshots the full counter.
- **Reads 0x30005–0x30007.** Return snapshot bytes 1–3, giving a coherent little-endian word.
- **Write 0x30000.** A nonzero byte is pushed to the TX FIFO; 0x00 is ignored.
- **Write 0x30004.** Pushes 0x00 tagged as the stop byte. `program_end` pulses in the cycle after that entry's `tx_valid && tx_ready` handshake.
- **Other I/O addresses.** Reads return 0x00; writes are ignored.
- **TX FIFO.**
  - `tx_valid` = (count != 0); `tx_data` = head entry.
  - A handshake pops the head entry.
  - A push is accepted if count < DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the push is dropped and `tx_overflow` sets.
  - Pointers wrap modulo DEPTH. Count is FIFO_DEPTH_BITS+1 bits wide.
- **`io_buffer_full`** = (count >= DEPTH − FULL_MARGIN), driven from the registered count.

## Timing
- **Read latency:** 1 cycle, back-to-back reads at full rate.
- **Write latency:** 0 cycles (committed at the edge).
- **Push to TX:** the pushed byte is visible on `tx_data`/`tx_valid` the cycle after the write.
- **Reset values:** `mem_rdata` = 0, `tx_valid` = 0, `tx_data` = 0, `io_buffer_full` = 0, `rx_pop` = 0, `program_end` = 0, `tx_overflow` = 0. Counter, snapshot and FIFO pointers are also cleared.
- **RAM contents are not cleared by reset.** Simulation preloads them with `$readmemh`.
- **Reset asserted mid-stream** flushes the FIFO. Any stop byte still pending never produces `program_end`.
- **Simultaneous push and pop at count = DEPTH:** both occur and count is unchanged.
- **Simultaneous push and pop at count = 0:** the push occurs, the pop cannot (`tx_valid` = 0), and count becomes 1.

## Configuration
- **`MEM_IO_UART_RX_EN` defined.**
  - A read of 0x30000 with `rx_valid` = 1 asserts `rx_pop` combinationally in the request cycle, and `mem_rdata` = `rx_data` next cycle.
  - With `rx_valid` = 0 the read returns 0x00 and `rx_pop` stays 0.
- **Macro undefined.** Reads of 0x30000 return 0x00, `rx_pop` is tied 0, and the RX ports are absent.

## Structure
- **Package `mem_io_pkg`:**
  - `IO_SEL` = 2'b11.
  - `IO_UART` = 18'h30000.
  - `IO_CLK` = 18'h30004.
  - Address-field ranges.
  - The TX entry type (8-bit data plus stop tag).
- **Sub-module `tx_fifo`:**
  - Parameterised synchronous FIFO.
  - Ports: push/pop/entry in and out, count, full, empty.
- **Top level** owns decode, RAM, counter/snapshot and the `program_end` logic.

## Test plan
- **RAM round-trip:** write 0xA5 @0x00010, then read @0x00010 the next cycle → `mem_rdata` = 0xA5 one cycle later.
- **Counter word:** after reset, read 0x30004–0x30007 starting at cycle 100 → bytes assemble to 100. This holds even though the counter advances during the reads.
- **TX back-pressure:** hold `tx_ready` = 0 and write 'H','i',0x00,'!' to 0x30000 → FIFO holds 3 entries (0x00 ignored). Continue to 14 entries → `io_buffer_full` = 1. At 16 entries a further write sets `tx_overflow` = 1 and count stays 16.
- **Stop sequence:** write 0x41 to 0x30000, then any byte to 0x30004, with `tx_ready` = 1 → `tx_data` 0x41 then 0x00, and `program_end` pulses exactly once, the cycle after the 0x00 handshake.
- **Reset mid-stream:** queue 5 bytes, assert `rst_in` for 1 cycle → `tx_valid` = 0, `io_buffer_full` = 0, and no `program_end`.
- **RX (`MEM_IO_UART_RX_EN`):** `rx_valid` = 1, `rx_data` = 0x37, read 0x30000 → `rx_pop` high in the request cycle and `mem_rdata` = 0x37 next cycle. With `rx_valid` = 0 → `mem_rdata` = 0x00.
